// File: rtl/imem_loader_if.sv
// Byte stream in and IMEM write port out, bundled between the boot loader and its
// surroundings. The loader sits on the slave side; the source/memory side is the master.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a counted, XOR-checksummed byte stream
// into little-endian words and keeps the core in reset until a good image is in place.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] n_q,        n_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       xor_q,      xor_d;
  logic [31:0]      word_q,     word_d;
  logic             wr_en_q,    wr_en_d;
  logic [31:0]      wr_addr_q,  wr_addr_d;
  logic [31:0]      wr_data_q,  wr_data_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;

  logic             in_load;
  logic             accept;
  logic [CNT_W-1:0] cnt_hdr;

  assign in_load = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                   (state_q == S_DATA) || (state_q == S_CHK);
  assign accept  = bus.rx_valid && in_load;
  assign cnt_hdr = CNT_W'({bus.rx_data, n_q[7:0]});

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    xor_d      = xor_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
          xor_d      = '0;
          state_d    = S_HDR0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          n_d[7:0] = bus.rx_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_d = cnt_hdr;
          if (cnt_hdr > CNT_W'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else if (cnt_hdr == '0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[byte_idx_q*8 +: 8] = bus.rx_data;
          xor_d      = xor_q ^ bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          // The word index stops at N-1 so it never points past the image.
          if (byte_idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = word_d;
            wr_addr_d = 32'({word_idx_q, 2'b00});
            if (word_idx_q == n_q - CNT_W'(1)) begin
              state_d = S_CHK;
            end else begin
              word_idx_d = word_idx_q + CNT_W'(1);
            end
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (bus.rx_data == xor_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      xor_q      <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      xor_q      <= xor_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Status is a pure decode of the state register, so it changes only on clock edges.
  assign bus.rx_ready = in_load;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = in_load;
  assign core_hold    = (state_q != S_DONE);
  assign done         = done_q;
  assign err          = err_q;

endmodule
